rv_iommu_axi4_abort_rsp: RTL and testbench
==========================================

// Module: rv_iommu_axi4_abort_rsp
// PURPOSE
// - Downstream of the AXI4 4-KiB boundary checker, in the IOMMU translation-request path.
// - When a request is flagged as a boundary violation, this block terminates it locally.
// - It is never forwarded to the memory side. Two independent FSMs: read and write.
// - Read: returns len+1 error R beats. Write: drains W beats up to WLAST, then returns one error B response.
// PARAMETERS
// - ID_WIDTH    default 4      AXI ID width of aborted transactions
// - DATA_WIDTH  default 64     R data width; data is always driven to zero
// - ERR_RESP    default 2'b10  response code returned (SLVERR); DECERR (2'b11) also legal
// PORTS
// - clk_i          in   1         single clock
// - rst_i          in   1         synchronous, active-high reset
// - rd_abort_i     in   1         read abort request (AR flagged as violation)
// - rd_id_i        in   ID_WIDTH  ARID of aborted read
// - rd_len_i       in   8         ARLEN (axi_pkg::len_t) of aborted read
// - rd_ready_o     out  1         read abort accepted this cycle when high with rd_abort_i
// - r_valid_o      out  1         R beat valid
// - r_id_o         out  ID_WIDTH  RID
// - r_data_o       out  DATA_WIDTH RDATA, constant 0
// - r_resp_o       out  2         RRESP = ERR_RESP
// - r_last_o       out  1         RLAST
// - r_ready_i      in   1         R beat consumed
// - wr_abort_i     in   1         write abort request (AW flagged as violation)
// - wr_id_i        in   ID_WIDTH  AWID of aborted write
// - wr_ready_o     out  1         write abort accepted this cycle when high with wr_abort_i
// - w_valid_i      in   1         W beat valid
// - w_last_i       in   1         WLAST
// - w_ready_o      out  1         W beat sunk (data discarded)
// - b_valid_o      out  1         B response valid
// - b_id_o         out  ID_WIDTH  BID
// - b_resp_o       out  2         BRESP = ERR_RESP
// - b_ready_i      in   1         B response consumed
// - abort_cnt_o    out  16        count of accepted aborts (see CONFIGURATION)
// BEHAVIOUR
// - All state is registered. On rst_i (at clk_i edge) both FSMs go to IDLE and all of the following are 0:
//   - r_valid_o, r_last_o, w_ready_o, b_valid_o, r_id_o, b_id_o, abort_cnt_o
//   - Reset mid-burst discards the transaction; no partial response is completed.
// - Read FSM RD_IDLE -> RD_BEATS -> RD_IDLE:
//   - rd_ready_o = 1 only in RD_IDLE (combinational from state).
//   - Accept (rd_abort_i & rd_ready_o) latches rd_id_i into the ID register and rd_len_i into an 8-bit beat counter.
//   - r_valid_o is 1 from the next cycle: 1-cycle latency.
//   - In RD_BEATS: r_valid_o = 1, r_last_o = (cnt == 0).
//   - Each r_valid_o & r_ready_i decrements cnt.
//   - The handshake with r_last_o returns to RD_IDLE. No new read is accepted in that same cycle.
//   - rd_len_i = 0 gives exactly 1 beat with r_last_o = 1. rd_len_i = 255 gives 256 beats; no counter wrap.
//   - Outputs hold stable while r_valid_o & !r_ready_i (AXI rule).
// - Write FSM WR_IDLE -> WR_DRAIN -> WR_RESP -> WR_IDLE:
//   - wr_ready_o = 1 only in WR_IDLE. Accept latches wr_id_i.
//   - In WR_DRAIN: w_ready_o = 1. Every W beat is sunk.
//   - The handshake with w_last_i moves to WR_RESP. Beat count is not checked; w_last_i alone ends the drain.
//   - W beats presented while in WR_IDLE see w_ready_o = 0 and are not consumed.
//   - In WR_RESP: b_valid_o = 1 until b_ready_i, then WR_IDLE.
//   - Minimum write abort with a single W beat present: accept at cycle N, W sunk at N+1, b_valid_o at N+2.
// - Read and write FSMs are fully independent. Simultaneous rd/wr aborts are both accepted in the same cycle.
// - Nothing is ever forwarded downstream.
// CONFIGURATION
// - Macro RV_IOMMU_ABORT_CNT_EN defined:
//   - abort_cnt_o increments by the number of aborts accepted in a cycle (0, 1 or 2).
//   - Saturates at 16'hFFFF and never wraps.
//   - Cleared only by rst_i.
// - Macro not defined: no counter logic; abort_cnt_o is tied to 16'h0.
// TESTING
// - rd_abort_i, id=3, len=3, r_ready_i=1 -> 4 beats on consecutive cycles starting at N+1.
//   - r_resp=2'b10, r_data=0, r_id=3; r_last only on beat 4.
// - len=0, r_ready_i held 0 for 5 cycles -> r_valid_o stays 1 with r_last=1 and stable id.
//   - Single beat completes when ready rises.
// - wr_abort_i id=5, 3 W beats with last on 3rd, b_ready_i=1 -> all 3 beats sunk.
//   - b_valid with b_id=5, b_resp=2'b10 the cycle after WLAST; then wr_ready_o=1.
// - rd and wr aborts in the same cycle -> both rd_ready_o and wr_ready_o are 1.
//   - Responses proceed concurrently; abort_cnt_o +2 (with macro) or stays 0 (without).
// - rst_i asserted at beat 2 of a len=7 read -> next cycle r_valid_o=0, rd_ready_o=1; a fresh abort is served normally.
// - Macro on, counter forced to 16'hFFFE, two single aborts -> abort_cnt_o reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/rv_iommu_axi4_abort_rsp.sv
// rv_iommu_axi4_abort_rsp
// Locally terminates AXI4 transactions flagged as 4-KiB boundary violations.
// Reads get len+1 error R beats; writes have their W beats drained up to
// WLAST and then receive one error B response. Nothing goes downstream.
// Optional macro RV_IOMMU_ABORT_CNT_EN enables a saturating count of
// accepted aborts on abort_cnt_o; without it abort_cnt_o is tied to zero.
module rv_iommu_axi4_abort_rsp #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter logic [1:0]  ERR_RESP   = 2'b10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rd_abort_i,
   input  logic [ID_WIDTH-1:0]   rd_id_i,
   input  logic [7:0]            rd_len_i,
   output logic                  rd_ready_o,
   output logic                  r_valid_o,
   output logic [ID_WIDTH-1:0]   r_id_o,
   output logic [DATA_WIDTH-1:0] r_data_o,
   output logic [1:0]            r_resp_o,
   output logic                  r_last_o,
   input  logic                  r_ready_i,
   input  logic                  wr_abort_i,
   input  logic [ID_WIDTH-1:0]   wr_id_i,
   output logic                  wr_ready_o,
   input  logic                  w_valid_i,
   input  logic                  w_last_i,
   output logic                  w_ready_o,
   output logic                  b_valid_o,
   output logic [ID_WIDTH-1:0]   b_id_o,
   output logic [1:0]            b_resp_o,
   input  logic                  b_ready_i,
   output logic [15:0]           abort_cnt_o
);

   typedef enum logic {RD_IDLE, RD_BEATS} rd_state_e;
   typedef enum logic [1:0] {WR_IDLE, WR_DRAIN, WR_RESP} wr_state_e;

   rd_state_e           rd_state_q, rd_state_d;
   logic [7:0]          rd_cnt_q, rd_cnt_d;
   logic [ID_WIDTH-1:0] rd_id_q, rd_id_d;
   wr_state_e           wr_state_q, wr_state_d;
   logic [ID_WIDTH-1:0] wr_id_q, wr_id_d;
   logic                rd_acc, wr_acc;

   // Read FSM: accept in idle, then stream error beats counting down to last
   always_comb begin
      rd_state_d = rd_state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_id_d    = rd_id_q;
      rd_ready_o = (rd_state_q == RD_IDLE);
      r_valid_o  = (rd_state_q == RD_BEATS);
      r_last_o   = (rd_state_q == RD_BEATS) && (rd_cnt_q == 8'd0);
      rd_acc     = rd_abort_i && rd_ready_o;
      unique case (rd_state_q)
         RD_IDLE: begin
            if (rd_acc) begin
               rd_id_d    = rd_id_i;
               rd_cnt_d   = rd_len_i;
               rd_state_d = RD_BEATS;
            end
         end
         RD_BEATS: begin
            if (r_ready_i) begin
               // Last beat leaves the counter at zero rather than wrapping
               if (r_last_o) rd_state_d = RD_IDLE;
               else          rd_cnt_d   = rd_cnt_q - 8'd1;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Write FSM: accept in idle, sink W until WLAST, then hold B until taken
   always_comb begin
      wr_state_d = wr_state_q;
      wr_id_d    = wr_id_q;
      wr_ready_o = (wr_state_q == WR_IDLE);
      w_ready_o  = (wr_state_q == WR_DRAIN);
      b_valid_o  = (wr_state_q == WR_RESP);
      wr_acc     = wr_abort_i && wr_ready_o;
      unique case (wr_state_q)
         WR_IDLE:  if (wr_acc) begin
                      wr_id_d    = wr_id_i;
                      wr_state_d = WR_DRAIN;
                   end
         WR_DRAIN: if (w_valid_i && w_last_i) wr_state_d = WR_RESP;
         WR_RESP:  if (b_ready_i) wr_state_d = WR_IDLE;
         default:  wr_state_d = WR_IDLE;
      endcase
   end

   // State registers; reset abandons any in-flight transaction
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_state_q <= RD_IDLE;
         rd_cnt_q   <= 8'd0;
         rd_id_q    <= '0;
         wr_state_q <= WR_IDLE;
         wr_id_q    <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_id_q    <= rd_id_d;
         wr_state_q <= wr_state_d;
         wr_id_q    <= wr_id_d;
      end
   end

   assign r_id_o   = rd_id_q;
   assign r_data_o = '0;
   assign r_resp_o = ERR_RESP;
   assign b_id_o   = wr_id_q;
   assign b_resp_o = ERR_RESP;

`ifdef RV_IOMMU_ABORT_CNT_EN
   logic [15:0] abort_cnt_q, abort_cnt_d;
   logic [16:0] abort_sum;

   // Saturating add of this cycle's accepted aborts (0..2)
   always_comb begin
      abort_sum   = {1'b0, abort_cnt_q} + {15'd0, rd_acc} + {15'd0, wr_acc};
      abort_cnt_d = abort_sum[16] ? 16'hFFFF : abort_sum[15:0];
   end

   // Counter register, cleared only by reset
   always_ff @(posedge clk_i) begin
      if (rst_i) abort_cnt_q <= 16'd0;
      else       abort_cnt_q <= abort_cnt_d;
   end

   assign abort_cnt_o = abort_cnt_q;
`else
   assign abort_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_rv_iommu_axi4_abort_rsp.sv
// Directed bench for rv_iommu_axi4_abort_rsp. Inputs change and outputs are
// sampled 1ns after the rising edge; the next edge consumes the inputs.
module tb_rv_iommu_axi4_abort_rsp;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rd_abort_i;
   logic [3:0]  rd_id_i;
   logic [7:0]  rd_len_i;
   logic        rd_ready_o;
   logic        r_valid_o;
   logic [3:0]  r_id_o;
   logic [63:0] r_data_o;
   logic [1:0]  r_resp_o;
   logic        r_last_o;
   logic        r_ready_i;
   logic        wr_abort_i;
   logic [3:0]  wr_id_i;
   logic        wr_ready_o;
   logic        w_valid_i;
   logic        w_last_i;
   logic        w_ready_o;
   logic        b_valid_o;
   logic [3:0]  b_id_o;
   logic [1:0]  b_resp_o;
   logic        b_ready_i;
   logic [15:0] abort_cnt_o;

   int nvec = 0;
   int nerr = 0;
   logic [15:0] exp_cnt = 16'd0;

   rv_iommu_axi4_abort_rsp dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_abort_i(rd_abort_i), .rd_id_i(rd_id_i), .rd_len_i(rd_len_i), .rd_ready_o(rd_ready_o),
      .r_valid_o(r_valid_o), .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
      .r_last_o(r_last_o), .r_ready_i(r_ready_i),
      .wr_abort_i(wr_abort_i), .wr_id_i(wr_id_i), .wr_ready_o(wr_ready_o),
      .w_valid_i(w_valid_i), .w_last_i(w_last_i), .w_ready_o(w_ready_o),
      .b_valid_o(b_valid_o), .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_ready_i(b_ready_i),
      .abort_cnt_o(abort_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs;
      rd_abort_i = 0; rd_id_i = 0; rd_len_i = 0; r_ready_i = 0;
      wr_abort_i = 0; wr_id_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst_i = 1;
      tick(); tick();
      rst_i = 0;
      nvec++; if ({r_valid_o, r_last_o, w_ready_o, b_valid_o} !== 4'b0000) begin
         nerr++; $display("FAIL reset_valids got=%b exp=0000", {r_valid_o, r_last_o, w_ready_o, b_valid_o}); end
      nvec++; if ({r_id_o, b_id_o} !== 8'h00) begin
         nerr++; $display("FAIL reset_ids got=%h exp=00", {r_id_o, b_id_o}); end
      nvec++; if (abort_cnt_o !== 16'h0) begin
         nerr++; $display("FAIL reset_cnt got=%h exp=0000", abort_cnt_o); end
      nvec++; if ({rd_ready_o, wr_ready_o} !== 2'b11) begin
         nerr++; $display("FAIL reset_ready got=%b exp=11", {rd_ready_o, wr_ready_o}); end
      exp_cnt = 16'd0;
   endtask

   task automatic test_read_basic;
      rd_abort_i = 1; rd_id_i = 4'd3; rd_len_i = 8'd3; r_ready_i = 1;
      nvec++; if (rd_ready_o !== 1'b1) begin
         nerr++; $display("FAIL rd_accept_ready got=%b exp=1", rd_ready_o); end
      tick();
      rd_abort_i = 0; rd_id_i = 4'd0; rd_len_i = 8'd0;
`ifdef RV_IOMMU_ABORT_CNT_EN
      exp_cnt = exp_cnt + 16'd1;
`endif
      for (int k = 0; k < 4; k++) begin
         nvec++; if ({r_valid_o, r_last_o, r_id_o, r_resp_o, rd_ready_o} !== {1'b1, (k == 3), 4'd3, 2'b10, 1'b0}) begin
            nerr++; $display("FAIL rd_beat%0d got v=%b l=%b id=%0d resp=%b rdy=%b exp v=1 l=%b id=3 resp=10 rdy=0",
                             k, r_valid_o, r_last_o, r_id_o, r_resp_o, rd_ready_o, (k == 3)); end
         nvec++; if (r_data_o !== 64'd0) begin
            nerr++; $display("FAIL rd_data%0d got=%h exp=0", k, r_data_o); end
         tick();
      end
      r_ready_i = 0;
      nvec++; if ({r_valid_o, rd_ready_o} !== 2'b01) begin
         nerr++; $display("FAIL rd_done got v=%b rdy=%b exp v=0 rdy=1", r_valid_o, rd_ready_o); end
   endtask

   task automatic test_read_stall;
      rd_abort_i = 1; rd_id_i = 4'd9; rd_len_i = 8'd0; r_ready_i = 0;
      tick();
      rd_abort_i = 0; rd_id_i = 4'd0;
`ifdef RV_IOMMU_ABORT_CNT_EN
      exp_cnt = exp_cnt + 16'd1;
`endif
      for (int k = 0; k < 5; k++) begin
         nvec++; if ({r_valid_o, r_last_o, r_id_o} !== {1'b1, 1'b1, 4'd9}) begin
            nerr++; $display("FAIL rd_stall%0d got v=%b l=%b id=%0d exp v=1 l=1 id=9", k, r_valid_o, r_last_o, r_id_o); end
         tick();
      end
      r_ready_i = 1;
      tick();
      r_ready_i = 0;
      nvec++; if ({r_valid_o, rd_ready_o} !== 2'b01) begin
         nerr++; $display("FAIL rd_stall_done got v=%b rdy=%b exp v=0 rdy=1", r_valid_o, rd_ready_o); end
   endtask

   task automatic test_write;
      // W beat offered while idle must not be consumed
      w_valid_i = 1; w_last_i = 1;
      nvec++; if (w_ready_o !== 1'b0) begin
         nerr++; $display("FAIL wr_idle_wready got=%b exp=0", w_ready_o); end
      tick();
      w_valid_i = 0; w_last_i = 0;
      nvec++; if ({wr_ready_o, b_valid_o} !== 2'b10) begin
         nerr++; $display("FAIL wr_idle_state got rdy=%b bv=%b exp rdy=1 bv=0", wr_ready_o, b_valid_o); end
      wr_abort_i = 1; wr_id_i = 4'd5; b_ready_i = 1;
      tick();
      wr_abort_i = 0; wr_id_i = 4'd0;
`ifdef RV_IOMMU_ABORT_CNT_EN
      exp_cnt = exp_cnt + 16'd1;
`endif
      for (int k = 0; k < 3; k++) begin
         w_valid_i = 1; w_last_i = (k == 2);
         nvec++; if ({w_ready_o, b_valid_o, wr_ready_o} !== 3'b100) begin
            nerr++; $display("FAIL wr_drain%0d got wr=%b bv=%b rdy=%b exp wr=1 bv=0 rdy=0", k, w_ready_o, b_valid_o, wr_ready_o); end
         tick();
      end
      w_valid_i = 0; w_last_i = 0;
      nvec++; if ({b_valid_o, b_id_o, b_resp_o, w_ready_o} !== {1'b1, 4'd5, 2'b10, 1'b0}) begin
         nerr++; $display("FAIL wr_bresp got bv=%b id=%0d resp=%b wr=%b exp bv=1 id=5 resp=10 wr=0", b_valid_o, b_id_o, b_resp_o, w_ready_o); end
      tick();
      b_ready_i = 0;
      nvec++; if ({b_valid_o, wr_ready_o} !== 2'b01) begin
         nerr++; $display("FAIL wr_done got bv=%b rdy=%b exp bv=0 rdy=1", b_valid_o, wr_ready_o); end
   endtask

   task automatic test_concurrent;
      rd_abort_i = 1; rd_id_i = 4'd2; rd_len_i = 8'd1;
      wr_abort_i = 1; wr_id_i = 4'd7;
      nvec++; if ({rd_ready_o, wr_ready_o} !== 2'b11) begin
         nerr++; $display("FAIL both_ready got=%b exp=11", {rd_ready_o, wr_ready_o}); end
      tick();
      rd_abort_i = 0; wr_abort_i = 0; rd_len_i = 0;
`ifdef RV_IOMMU_ABORT_CNT_EN
      exp_cnt = exp_cnt + 16'd2;
`endif
      r_ready_i = 1; w_valid_i = 1; w_last_i = 1; b_ready_i = 1;
      nvec++; if ({r_valid_o, r_last_o, r_id_o, w_ready_o} !== {1'b1, 1'b0, 4'd2, 1'b1}) begin
         nerr++; $display("FAIL conc_c1 got rv=%b rl=%b id=%0d wr=%b exp rv=1 rl=0 id=2 wr=1", r_valid_o, r_last_o, r_id_o, w_ready_o); end
      tick();
      w_valid_i = 0; w_last_i = 0;
      nvec++; if ({r_valid_o, r_last_o, b_valid_o, b_id_o} !== {1'b1, 1'b1, 1'b1, 4'd7}) begin
         nerr++; $display("FAIL conc_c2 got rv=%b rl=%b bv=%b bid=%0d exp rv=1 rl=1 bv=1 bid=7", r_valid_o, r_last_o, b_valid_o, b_id_o); end
      tick();
      idle_inputs();
      nvec++; if ({r_valid_o, b_valid_o, rd_ready_o, wr_ready_o} !== 4'b0011) begin
         nerr++; $display("FAIL conc_done got=%b exp=0011", {r_valid_o, b_valid_o, rd_ready_o, wr_ready_o}); end
      nvec++; if (abort_cnt_o !== exp_cnt) begin
         nerr++; $display("FAIL conc_cnt got=%h exp=%h", abort_cnt_o, exp_cnt); end
   endtask

   task automatic test_reset_midburst;
      rd_abort_i = 1; rd_id_i = 4'd4; rd_len_i = 8'd7; r_ready_i = 1;
      tick();
      rd_abort_i = 0; rd_len_i = 0;
      tick();   // beat 1 consumed, now presenting beat 2
      nvec++; if ({r_valid_o, r_last_o} !== 2'b10) begin
         nerr++; $display("FAIL mid_beat2 got v=%b l=%b exp v=1 l=0", r_valid_o, r_last_o); end
      rst_i = 1;
      tick();
      rst_i = 0; r_ready_i = 0;
      exp_cnt = 16'd0;
      nvec++; if ({r_valid_o, rd_ready_o, r_id_o} !== {1'b0, 1'b1, 4'd0}) begin
         nerr++; $display("FAIL mid_reset got v=%b rdy=%b id=%0d exp v=0 rdy=1 id=0", r_valid_o, rd_ready_o, r_id_o); end
      nvec++; if (abort_cnt_o !== 16'h0) begin
         nerr++; $display("FAIL mid_reset_cnt got=%h exp=0000", abort_cnt_o); end
      rd_abort_i = 1; rd_id_i = 4'd1; rd_len_i = 8'd0; r_ready_i = 1;
      tick();
      rd_abort_i = 0; rd_id_i = 0;
`ifdef RV_IOMMU_ABORT_CNT_EN
      exp_cnt = exp_cnt + 16'd1;
`endif
      nvec++; if ({r_valid_o, r_last_o, r_id_o} !== {1'b1, 1'b1, 4'd1}) begin
         nerr++; $display("FAIL fresh_beat got v=%b l=%b id=%0d exp v=1 l=1 id=1", r_valid_o, r_last_o, r_id_o); end
      tick();
      r_ready_i = 0;
      nvec++; if ({r_valid_o, rd_ready_o} !== 2'b01) begin
         nerr++; $display("FAIL fresh_done got v=%b rdy=%b exp v=0 rdy=1", r_valid_o, rd_ready_o); end
      nvec++; if (abort_cnt_o !== exp_cnt) begin
         nerr++; $display("FAIL fresh_cnt got=%h exp=%h", abort_cnt_o, exp_cnt); end
   endtask

   task automatic test_len255;
      rd_abort_i = 1; rd_id_i = 4'hF; rd_len_i = 8'd255; r_ready_i = 1;
      tick();
      rd_abort_i = 0; rd_len_i = 0;
`ifdef RV_IOMMU_ABORT_CNT_EN
      exp_cnt = exp_cnt + 16'd1;
`endif
      for (int k = 0; k < 256; k++) begin
         if (k == 0 || k >= 254) begin
            nvec++; if ({r_valid_o, r_last_o} !== {1'b1, (k == 255)}) begin
               nerr++; $display("FAIL len255_beat%0d got v=%b l=%b exp v=1 l=%b", k, r_valid_o, r_last_o, (k == 255)); end
         end
         tick();
      end
      r_ready_i = 0;
      nvec++; if ({r_valid_o, rd_ready_o} !== 2'b01) begin
         nerr++; $display("FAIL len255_done got v=%b rdy=%b exp v=0 rdy=1", r_valid_o, rd_ready_o); end
   endtask

`ifdef RV_IOMMU_ABORT_CNT_EN
   task automatic test_saturate;
      force dut.abort_cnt_q = 16'hFFFE;
      #1;
      release dut.abort_cnt_q;
      for (int k = 0; k < 2; k++) begin
         rd_abort_i = 1; rd_len_i = 8'd0; r_ready_i = 1;
         tick();
         rd_abort_i = 0;
         tick();
      end
      r_ready_i = 0;
      nvec++; if (abort_cnt_o !== 16'hFFFF) begin
         nerr++; $display("FAIL cnt_sat got=%h exp=ffff", abort_cnt_o); end
      tick(); tick();
      nvec++; if (abort_cnt_o !== 16'hFFFF) begin
         nerr++; $display("FAIL cnt_sat_hold got=%h exp=ffff", abort_cnt_o); end
   endtask
`endif

   initial begin
      rst_i = 1;
      idle_inputs();
      test_reset();
      test_read_basic();
      test_read_stall();
      test_write();
      test_concurrent();
      test_reset_midburst();
      test_len255();
`ifdef RV_IOMMU_ABORT_CNT_EN
      test_saturate();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached exp=finish");
      $fatal(1, "timeout");
   end
endmodule
